fir_line_window: RTL



---
 rtl/fir_line_window.sv | 111 +++++++++++
 1 files changed

// File: rtl/fir_line_window.sv
// fir_line_window: five-row vertical window feeder for the 5x5 systolic FIR.
// Raster pixels go in. Each beat presents rows r-4..r of the current column.
// The four previous lines share one packed memory word per column:
// {L4, L3, L2, L1}. Writing the word back shifted by one pixel ages every
// line in a single access.
// Optional build macro FIR_LINE_WINDOW_BORDER_REPLICATE_EN: the window is
// valid from row 0, and slots above the frame top replicate row 0.
module fir_line_window #(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 10,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    output logic [DATA_W-1:0] pixel0,
    output logic [DATA_W-1:0] pixel1,
    output logic [DATA_W-1:0] pixel2,
    output logic [DATA_W-1:0] pixel3,
    output logic [DATA_W-1:0] pixel4,
    output logic              out_last
);

    localparam int unsigned LAST_COL = IMG_WIDTH - 1;

    logic [4*DATA_W-1:0] line_mem [IMG_WIDTH];

    logic [COL_W-1:0]    col;
    logic [2:0]          rows_filled;
    logic [COL_W-1:0]    beat_col;
    logic [2:0]          beat_rows;
    logic [4*DATA_W-1:0] old_lines;
    logic                at_last;
    logic                beat_valid;
    logic [DATA_W-1:0]   depth [5];
    logic [DATA_W-1:0]   slot  [5];

    // Position of the current beat; sof forces it to the frame origin.
    always_comb begin
        beat_col  = in_sof ? '0 : col;
        beat_rows = in_sof ? '0 : rows_filled;
        old_lines = line_mem[beat_col];
        at_last   = (beat_col == COL_W'(LAST_COL));
        depth[0]  = in_pixel;
        for (int unsigned k = 1; k < 5; k++) begin
            depth[k] = old_lines[(k-1)*DATA_W +: DATA_W];
        end
    end

`ifdef FIR_LINE_WINDOW_BORDER_REPLICATE_EN
    // Slots deeper than the rows seen so far take the row-0 pixel (depth rows_filled).
    always_comb begin
        beat_valid = in_valid;
        for (int unsigned k = 0; k < 5; k++) begin
            slot[k] = (k > 32'(beat_rows)) ? depth[beat_rows] : depth[k];
        end
    end
`else
    // The window is valid only once four full lines are stored.
    always_comb begin
        beat_valid = in_valid && (beat_rows == 3'd4);
        for (int unsigned k = 0; k < 5; k++) begin
            slot[k] = depth[k];
        end
    end
`endif

    // Age the column's four lines by one row: read before write on the same word.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            line_mem[beat_col] <= {old_lines[3*DATA_W-1:0], in_pixel};
        end
    end

    // Registered window outputs and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            rows_filled <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            pixel0      <= '0;
            pixel1      <= '0;
            pixel2      <= '0;
            pixel3      <= '0;
            pixel4      <= '0;
        end else if (in_valid) begin
            pixel4    <= slot[0];
            pixel3    <= slot[1];
            pixel2    <= slot[2];
            pixel1    <= slot[3];
            pixel0    <= slot[4];
            out_valid <= beat_valid;
            out_last  <= beat_valid && at_last;
            if (at_last) begin
                col         <= '0;
                rows_filled <= (beat_rows == 3'd4) ? 3'd4 : beat_rows + 3'd1;
            end else begin
                col         <= beat_col + COL_W'(1);
                rows_filled <= beat_rows;
            end
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
